// File: rtl/centroid_update_ctrl.sv
// K-means centroid update controller: accumulates per-cluster RGB sums and counts,
// then drives a 16-lane divider for R, G and B and captures the means as centroids.
module centroid_update_ctrl #(
    parameter int NUM_CLUSTERS = 16,
    parameter int COMP_W       = 8,
    parameter int SUM_W        = 20,
    parameter int CNT_W        = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [COMP_W-1:0]              pix_r,
    input  logic [COMP_W-1:0]              pix_g,
    input  logic [COMP_W-1:0]              pix_b,
    input  logic [3:0]                     pix_cluster,
    input  logic                           pix_last,
    output logic                           div_ce,
    output logic [NUM_CLUSTERS-1:0]        div_en,
    output logic [NUM_CLUSTERS*SUM_W-1:0]  div_dividend,
    output logic [NUM_CLUSTERS*CNT_W-1:0]  div_divisor,
    input  logic                           div_all_ready,
    input  logic [NUM_CLUSTERS*SUM_W-1:0]  div_q,
    output logic [NUM_CLUSTERS*COMP_W-1:0] cent_r,
    output logic [NUM_CLUSTERS*COMP_W-1:0] cent_g,
    output logic [NUM_CLUSTERS*COMP_W-1:0] cent_b,
    output logic                           cent_valid,
    output logic                           busy,
    output logic                           sat_err
);

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_comp;
    logic              r_first;
    logic              r_sat_err;
    logic [SUM_W-1:0]  r_sum_r [NUM_CLUSTERS];
    logic [SUM_W-1:0]  r_sum_g [NUM_CLUSTERS];
    logic [SUM_W-1:0]  r_sum_b [NUM_CLUSTERS];
    logic [CNT_W-1:0]  r_cnt   [NUM_CLUSTERS];
    logic [COMP_W-1:0] r_cent_r [NUM_CLUSTERS];
    logic [COMP_W-1:0] r_cent_g [NUM_CLUSTERS];
    logic [COMP_W-1:0] r_cent_b [NUM_CLUSTERS];
    logic [NUM_CLUSTERS-1:0] w_mask;
    logic              w_accept;
    logic              w_capture;
    logic              w_unused_q;

    assign w_accept  = pix_valid && (r_state == ST_ACCUM);
    // The first WAIT cycle is skipped: the divider reports ready trivially while en settles.
    assign w_capture = (r_state == ST_WAIT) && !r_first && div_all_ready;

    assign pix_ready  = (r_state == ST_ACCUM);
    assign busy       = (r_state != ST_ACCUM);
    assign cent_valid = (r_state == ST_DONE);
    assign div_ce     = (r_state == ST_SETUP) || (r_state == ST_WAIT) || (r_state == ST_GAP);
    assign div_en     = (r_state == ST_WAIT) ? w_mask : {NUM_CLUSTERS{1'b0}};
    assign sat_err    = r_sat_err;

    // Lane packing of divider operands, centroid outputs and the active-lane mask.
    always_comb begin
        div_dividend = {(NUM_CLUSTERS*SUM_W){1'b0}};
        div_divisor  = {(NUM_CLUSTERS*CNT_W){1'b0}};
        cent_r       = {(NUM_CLUSTERS*COMP_W){1'b0}};
        cent_g       = {(NUM_CLUSTERS*COMP_W){1'b0}};
        cent_b       = {(NUM_CLUSTERS*COMP_W){1'b0}};
        w_mask       = {NUM_CLUSTERS{1'b0}};
        w_unused_q   = 1'b0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            case (r_comp)
                2'd0:    div_dividend[i*SUM_W +: SUM_W] = r_sum_r[i];
                2'd1:    div_dividend[i*SUM_W +: SUM_W] = r_sum_g[i];
                2'd2:    div_dividend[i*SUM_W +: SUM_W] = r_sum_b[i];
                default: div_dividend[i*SUM_W +: SUM_W] = {SUM_W{1'b0}};
            endcase
            div_divisor[i*CNT_W +: CNT_W] = r_cnt[i];
            cent_r[i*COMP_W +: COMP_W]    = r_cent_r[i];
            cent_g[i*COMP_W +: COMP_W]    = r_cent_g[i];
            cent_b[i*COMP_W +: COMP_W]    = r_cent_b[i];
            w_mask[i]                     = (r_cnt[i] != {CNT_W{1'b0}});
            w_unused_q = w_unused_q ^ (^div_q[i*SUM_W+COMP_W +: SUM_W-COMP_W]);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && pix_last) w_state_next = ST_SETUP;
                else                      w_state_next = ST_ACCUM;
            end
            ST_SETUP: begin
                if (w_mask == {NUM_CLUSTERS{1'b0}}) w_state_next = ST_DONE;
                else                                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_capture) w_state_next = ST_GAP;
                else           w_state_next = ST_WAIT;
            end
            ST_GAP: begin
                if (r_comp == 2'd2) w_state_next = ST_DONE;
                else                w_state_next = ST_SETUP;
            end
            ST_DONE:  w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    // State, component index and first-WAIT-cycle flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
            r_comp  <= 2'd0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_first <= (r_state == ST_SETUP);
            if (r_state == ST_DONE)     r_comp <= 2'd0;
            else if (r_state == ST_GAP) r_comp <= r_comp + 2'd1;
            else                        r_comp <= r_comp;
        end
    end

    // Accumulators, saturation flag and centroid capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_err <= 1'b0;
            for (int i = 0; i < NUM_CLUSTERS; i++) begin
                r_sum_r[i]  <= {SUM_W{1'b0}};
                r_sum_g[i]  <= {SUM_W{1'b0}};
                r_sum_b[i]  <= {SUM_W{1'b0}};
                r_cnt[i]    <= {CNT_W{1'b0}};
                r_cent_r[i] <= {COMP_W{1'b0}};
                r_cent_g[i] <= {COMP_W{1'b0}};
                r_cent_b[i] <= {COMP_W{1'b0}};
            end
        end else begin
            if (r_state == ST_DONE) begin
                for (int i = 0; i < NUM_CLUSTERS; i++) begin
                    r_sum_r[i] <= {SUM_W{1'b0}};
                    r_sum_g[i] <= {SUM_W{1'b0}};
                    r_sum_b[i] <= {SUM_W{1'b0}};
                    r_cnt[i]   <= {CNT_W{1'b0}};
                end
            end else if (w_accept) begin
                if (r_cnt[pix_cluster] == CNT_MAX) begin
                    r_sat_err <= 1'b1;
                end else begin
                    r_sum_r[pix_cluster] <= r_sum_r[pix_cluster] + {{(SUM_W-COMP_W){1'b0}}, pix_r};
                    r_sum_g[pix_cluster] <= r_sum_g[pix_cluster] + {{(SUM_W-COMP_W){1'b0}}, pix_g};
                    r_sum_b[pix_cluster] <= r_sum_b[pix_cluster] + {{(SUM_W-COMP_W){1'b0}}, pix_b};
                    r_cnt[pix_cluster]   <= r_cnt[pix_cluster] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            if (w_capture) begin
                for (int i = 0; i < NUM_CLUSTERS; i++) begin
                    if (w_mask[i]) begin
                        case (r_comp)
                            2'd0:    r_cent_r[i] <= div_q[i*SUM_W +: COMP_W];
                            2'd1:    r_cent_g[i] <= div_q[i*SUM_W +: COMP_W];
                            2'd2:    r_cent_b[i] <= div_q[i*SUM_W +: COMP_W];
                            default: r_cent_r[i] <= r_cent_r[i];
                        endcase
                    end
                end
            end
        end
    end

endmodule
